spi_jtag_framer: RTL and testbench
==================================

# spi_jtag_framer

Length-framed JTAG-to-SPI bridge stage, sitting between a BSCAN user-chain endpoint and the SPI flash pins (STARTUP primitive or fabric IOs). Each DR scan carries a 16-bit header giving the payload bit count. The block then drives exactly that many SPI clocks with CS asserted and returns flash MISO on TDO. CS releases automatically at the end of the payload, so trailing pad bits never reach the flash.

## Interface
- HDR_W, 16: header length in bits, shifted LSB first.
- LEN_W, 13: payload-length field width, header bits [LEN_W-1:0]; remaining header bits reserved, ignored.
- clk  in  1  DRCK from BSCAN; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sel  in  1  user instruction selected; all controls qualified with sel.
- capture  in  1  TAP Capture-DR.
- shift  in  1  TAP Shift-DR.
- update  in  1  TAP Update-DR.
- tdi  in  1  scan data in.
- tdo  out  1  scan data out (registered MISO).
- csn  out  1  flash chip select, active-low.
- sck_en  out  1  registered SPI clock enable; parent forms sck = ~clk & sck_en.
- sdi_dq0  out  1  MOSI.
- sdo_dq1  in  1  MISO.
- wpn_dq2  out  1  constant 1.
- hldn_dq3  out  1  constant 1.
- busy  out  1  high in HEADER or XFER.

## Operation
- States: IDLE, HEADER, XFER, DONE.
- IDLE: on capture&&sel -> HEADER, bit counter = 0, header register cleared.
- HEADER: each shift&&sel shifts tdi into hdr[cnt]; cnt increments.
  - On the HDR_W-th bit: len = hdr[LEN_W-1:0].
  - len != 0 -> XFER with remaining = len.
  - len == 0 -> XFER in streaming mode (no countdown).
- XFER: csn = 0, sck_en = 1 while shift&&sel.
  - sdi_dq0 <= tdi each qualified shift.
  - tdo <= sdo_dq1 each qualified shift.
  - remaining decrements per bit; on the bit where remaining == 1 -> DONE.
  - Streaming: stays in XFER until update.
  - shift deasserted (Pause-DR): csn held low, sck_en = 0, counters frozen.
- DONE: csn = 1, sck_en = 0; further shifts ignored, tdo = 0. update&&sel -> IDLE.
- update&&sel in any state -> IDLE, csn = 1, sck_en = 0 next edge. This is the abort path.
- capture&&sel in XFER/DONE -> HEADER; csn rises on the same edge.
- sel low: no state change, sck_en = 0.
- Width rule: remaining is LEN_W bits unsigned; max payload 2^LEN_W-1 = 8191 bits; no wrap, decrement stops at the DONE transition.

## Timing
- Reset values: csn = 1, sck_en = 0, sdi_dq0 = 0, tdo = 0, busy = 0, wpn_dq2 = 1, hldn_dq3 = 1, state IDLE.
- rst asserted mid-XFER: csn = 1 immediately (asynchronous), no further SPI clocks.
- Header to SPI:
  - csn falls on the edge that consumes the last header bit.
  - The first sck falling-then-rising pair occurs on the next qualified shift.
  - MOSI bit k is valid from edge k+HDR_W+1; the flash samples it on rising sck (~clk high half).
- TDO latency: one DRCK.
  - The host shifts HDR_W+len+1 bits total.
  - Returned bit 0 of the payload appears at scan position HDR_W+1.
- CS release: csn rises on the edge after the last payload bit, before Exit1-DR.
- Outputs are registered except wpn_dq2/hldn_dq3 (constant).

## Structure
- Package spi_jtag_pkg: state enum (IDLE, HEADER, XFER, DONE), HDR_W/LEN_W defaults, constant LEN_STREAM = 0.
- Single module, no sub-module. The header shifter and down-counter are inline; the gated sck is formed in the parent wrapper.

## Test plan
- Reset: hold rst with sel=1, shift toggling -> csn=1, sck_en=0, tdo=0, busy=0 throughout.
- Header len=8, payload 0x9F LSB first, flash model returns 0xEF -> exactly 8 sck pulses; csn low 8 bits then high before update; tdo bits HDR_W+1..HDR_W+8 = 0xEF LSB first.
- Header len=3 with 10 trailing pad bits -> 3 sck pulses only; DONE holds csn=1; tdo=0 for pad bits.
- Header len=0 (streaming), 40 payload bits, then update -> 40 sck pulses; csn rises on the update edge.
- Abort: len=100, update after 20 payload bits -> 20 sck pulses, csn=1 next edge, state IDLE. A new capture restarts HEADER with cnt=0.
- Pause-DR mid-XFER for 5 cycles with len=16 -> csn stays 0, no sck, count resumes; 16 total pulses.

Source files
------------

// File: rtl/spi_jtag_pkg.sv
// spi_jtag_pkg: shared state encoding and default widths for the JTAG-to-SPI framer
package spi_jtag_pkg;
  localparam int HDR_W = 16;
  localparam int LEN_W = 13;
  localparam int LEN_STREAM = 0;
  typedef enum logic [1:0] {IDLE, HEADER, XFER, DONE} state_t;
endpackage

// File: rtl/spi_jtag_framer_if.sv
// spi_jtag_framer_if: BSCAN user-chain controls plus SPI flash pins
//   sel/capture/shift/update/tdi/tdo : TAP side
//   csn/sck_en/sdi_dq0/sdo_dq1/wpn_dq2/hldn_dq3 : flash side
//   busy : framer in HEADER or XFER
interface spi_jtag_framer_if;
  logic sel, capture, shift, update, tdi, tdo;
  logic csn, sck_en, sdi_dq0, sdo_dq1, wpn_dq2, hldn_dq3, busy;
  modport slave (
    input  sel, capture, shift, update, tdi, sdo_dq1,
    output tdo, csn, sck_en, sdi_dq0, wpn_dq2, hldn_dq3, busy
  );
  modport master (
    output sel, capture, shift, update, tdi, sdo_dq1,
    input  tdo, csn, sck_en, sdi_dq0, wpn_dq2, hldn_dq3, busy
  );
endinterface

// File: rtl/spi_jtag_framer.sv
// spi_jtag_framer: length-framed JTAG DR scan to SPI flash bridge
//   clk    : DRCK, all logic on posedge
//   rst    : asynchronous active-high reset
//   io_bus : TAP controls in, flash pins out (slave modport)
// A 16-bit LSB-first header carries the payload length; exactly that many
// SPI clocks follow with CS low, then CS releases so pad bits never reach the flash.
module spi_jtag_framer #(
  parameter int HDR_W = spi_jtag_pkg::HDR_W,
  parameter int LEN_W = spi_jtag_pkg::LEN_W
) (
  input logic clk,
  input logic rst,
  spi_jtag_framer_if.slave io_bus
);
  import spi_jtag_pkg::*;
  localparam int CNT_W = $clog2(HDR_W);
  state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [HDR_W-1:0] r_hdr, w_hdr_nx;
  logic [LEN_W-1:0] r_rem, w_rem_nx;
  logic r_stream, w_stream_nx, r_csn, w_csn_nx, r_sck_en, w_sck_en_nx;
  logic r_sdi, w_sdi_nx, r_tdo, w_tdo_nx, r_busy;
  logic w_cap, w_upd, w_shf, w_last_hdr, w_last_bit;
  assign w_cap = io_bus.capture & io_bus.sel;
  assign w_upd = io_bus.update & io_bus.sel;
  assign w_shf = io_bus.shift & io_bus.sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hdr    <= '0;
      r_rem    <= '0;
      r_stream <= 1'b0;
      r_csn    <= 1'b1;
      r_sck_en <= 1'b0;
      r_sdi    <= 1'b0;
      r_tdo    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_hdr    <= w_hdr_nx;
      r_rem    <= w_rem_nx;
      r_stream <= w_stream_nx;
      r_csn    <= w_csn_nx;
      r_sck_en <= w_sck_en_nx;
      r_sdi    <= w_sdi_nx;
      r_tdo    <= w_tdo_nx;
      r_busy   <= (w_state_nx == HEADER) || (w_state_nx == XFER);
    end
  end
  // Abort (update) outranks restart (capture), which outranks shifting.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_hdr_nx    = r_hdr;
    w_rem_nx    = r_rem;
    w_stream_nx = r_stream;
    w_sdi_nx    = r_sdi;
    w_last_hdr  = (r_state == HEADER) && w_shf && (r_cnt == CNT_W'(HDR_W - 1));
    w_last_bit  = (r_state == XFER) && w_shf && !r_stream && (r_rem == LEN_W'(1));
    if (w_upd) w_state_nx = IDLE;
    else if (w_cap) begin
      w_state_nx = HEADER;
      w_cnt_nx   = '0;
      w_hdr_nx   = '0;
    end else if (w_shf && r_state == HEADER) begin
      w_hdr_nx[r_cnt] = io_bus.tdi;
      w_cnt_nx        = r_cnt + CNT_W'(1);
      if (w_last_hdr) begin
        w_state_nx  = XFER;
        w_rem_nx    = w_hdr_nx[LEN_W-1:0];
        w_stream_nx = w_hdr_nx[LEN_W-1:0] == LEN_W'(LEN_STREAM);
      end
    end else if (w_shf && r_state == XFER) begin
      w_sdi_nx = io_bus.tdi;
      if (w_last_bit) w_state_nx = DONE;
      else if (!r_stream) w_rem_nx = r_rem - LEN_W'(1);
    end
    w_sck_en_nx = (r_state == XFER) && w_shf && !w_upd && !w_cap;
    // CS stays low through the last payload bit's clock and releases one edge later.
    w_csn_nx = !((w_state_nx == XFER) || (r_state == XFER && w_state_nx == DONE));
    w_tdo_nx = (r_state != XFER) ? 1'b0 : w_shf ? io_bus.sdo_dq1 : r_tdo;
  end
  assign io_bus.tdo      = r_tdo;
  assign io_bus.csn      = r_csn;
  assign io_bus.sck_en   = r_sck_en;
  assign io_bus.sdi_dq0  = r_sdi;
  assign io_bus.busy     = r_busy;
  assign io_bus.wpn_dq2  = 1'b1;
  assign io_bus.hldn_dq3 = 1'b1;
endmodule

// File: tb/tb_spi_jtag_framer.sv
// tb_spi_jtag_framer: directed and randomized DR scans checked against a scan-level model
module tb_spi_jtag_framer;
  import spi_jtag_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  spi_jtag_framer_if bus();
  spi_jtag_framer dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic s, input logic c, input logic sh, input logic u, input logic d, input logic q);
    @(negedge clk);
    bus.sel = s;
    bus.capture = c;
    bus.shift = sh;
    bus.update = u;
    bus.tdi = d;
    bus.sdo_dq1 = q;
    @(posedge clk);
    #1;
    if (bus.sck_en === 1'b1) pulses++;
  endtask
  // One DR scan: capture, header, n payload bits (optional pause / async reset), optional update.
  // Model: payload bit i is clocked to the flash iff len==0 or i<len; CS is high once i>=len.
  task automatic scan(input int len, input int n, input bit upd, input int pause_at, input int pause_len,
                      input bit pause_sel, input int rst_at, input logic [63:0] dpat, input logic [63:0] qpat,
                      input bit fixed);
    logic [HDR_W-1:0] hdr;
    logic d, q;
    bit act;
    int exp_p;
    hdr = HDR_W'($urandom);
    hdr[LEN_W-1:0] = LEN_W'(len);
    tick(1, 1, 0, 0, 0, 0);
    chk("cap_busy", bus.busy, 1'b1);
    chk("cap_csn", bus.csn, 1'b1);
    for (int h = 0; h < HDR_W; h++) begin
      tick(1, 0, 1, 0, hdr[h], 1'($urandom));
      chk("hdr_csn", bus.csn, (h == HDR_W - 1) ? 1'b0 : 1'b1);
      chk("hdr_sck", bus.sck_en, 1'b0);
    end
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          if (pause_sel) tick(0, 0, 1, 0, 1'($urandom), 1'($urandom));
          else tick(1, 0, 0, 0, 1'($urandom), 1'($urandom));
          chk("pause_sck", bus.sck_en, 1'b0);
          chk("pause_csn", bus.csn, len != 0 && i >= len);
        end
      end
      d = fixed ? dpat[i[5:0]] : 1'($urandom);
      q = fixed ? qpat[i[5:0]] : 1'($urandom);
      act = (len == 0) || (i < len);
      tick(1, 0, 1, 0, d, q);
      chk("sck", bus.sck_en, act);
      chk("csn", bus.csn, !act);
      chk("tdo", bus.tdo, act ? q : 1'b0);
      if (act) chk("mosi", bus.sdi_dq0, d);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_csn", bus.csn, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
        chk("arst_sck", bus.sck_en, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk_int("arst_pulses", pulses, rst_at + 1);
        repeat (3) begin
          tick(1, 0, 1, 0, 1'($urandom), 1'($urandom));
          chk("arst_hold_csn", bus.csn, 1'b1);
        end
        chk_int("arst_no_sck", pulses, rst_at + 1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    exp_p = (len == 0) ? n : ((n < len) ? n : len);
    chk_int("pulses", pulses, exp_p);
    if (upd) begin
      tick(1, 0, 0, 1, 0, 0);
      chk("upd_csn", bus.csn, 1'b1);
      chk("upd_sck", bus.sck_en, 1'b0);
      chk("upd_busy", bus.busy, 1'b0);
    end
  endtask
  initial begin
    bus.sel = 1'b1;
    bus.capture = 1'b0;
    bus.shift = 1'b0;
    bus.update = 1'b0;
    bus.tdi = 1'b0;
    bus.sdo_dq1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1, k == 1, k[0], 0, 1'($urandom), 1'($urandom));
      chk("rst_csn", bus.csn, 1'b1);
      chk("rst_sck", bus.sck_en, 1'b0);
      chk("rst_tdo", bus.tdo, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mosi", bus.sdi_dq0, 1'b0);
    end
    chk("wpn", bus.wpn_dq2, 1'b1);
    chk("hldn", bus.hldn_dq3, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    scan(8, 9, 1, -1, 0, 0, -1, 64'h9F, 64'hEF, 1);
    scan(3, 13, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(0, 40, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(100, 20, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(16, 17, 1, 7, 5, 0, -1, 64'h0, 64'h0, 0);
    scan(16, 17, 1, 4, 3, 1, -1, 64'h0, 64'h0, 0);
    scan(5, 8, 1, 6, 2, 0, -1, 64'h0, 64'h0, 0);
    scan(1, 3, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(0, 10, 0, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(6, 9, 0, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(4, 5, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(8191, 8192, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    scan(50, 50, 1, -1, 0, 0, 10, 64'h0, 64'h0, 0);
    scan(7, 8, 1, -1, 0, 0, -1, 64'h0, 64'h0, 0);
    repeat (8) scan($urandom_range(1, 40), $urandom_range(1, 50), 1, $urandom_range(0, 30),
                    $urandom_range(0, 4), 1'($urandom), -1, 64'h0, 64'h0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
